// File: rtl/nes_pkg.sv
// Shared constants and types for the NES pad-link responder.
package nes_pkg;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam int NES_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFTING,
        DONE
    } resp_state_t;

endpackage

// File: rtl/nes_edge_sync.sv
// 2-flop synchronizer plus registered rise/fall detect for one async console line.
// Edges appear 2 cycles after the pin changes, aligned with the new synchronized level; no backpressure.
module nes_edge_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic in_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q, s2_q, rise_q, fall_q;

    // Edge flags are computed from the stage-1 vs stage-2 difference so they line up with level_o.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= in_i;
            s2_q   <= s1_q;
            rise_q <= s1_q & ~s2_q;
            fall_q <= ~s1_q & s2_q;
        end
    end

    assign level_o = s2_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/nes_controller_responder.sv
// Gamepad-side 4021 emulation: latch captures buttons, each shift-clock rise moves out the next bit.
// Pin-to-pin latency at most 4 cycles; the console paces the link, there is no backpressure.
module nes_controller_responder #(
    parameter bit INVERT         = 1'b1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk_900KHz,
    input  logic reset,
    input  logic latch_in,
    input  logic nesclk_in,
    input  logic a,
    input  logic b,
    input  logic select,
    input  logic start,
    input  logic up,
    input  logic down,
    input  logic left,
    input  logic right,
    output logic data_out,
    output logic busy,
    output logic frame_done
);
    import nes_pkg::*;

    localparam int               TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic             REL      = INVERT;

    logic latch_lvl, latch_rise, latch_fall;
    logic nclk_lvl, nclk_rise, nclk_fall;

    nes_edge_sync u_latch_sync (
        .clk_i   (clk_900KHz),
        .rst_i   (reset),
        .in_i    (latch_in),
        .level_o (latch_lvl),
        .rise_o  (latch_rise),
        .fall_o  (latch_fall)
    );

    nes_edge_sync u_nclk_sync (
        .clk_i   (clk_900KHz),
        .rst_i   (reset),
        .in_i    (nesclk_in),
        .level_o (nclk_lvl),
        .rise_o  (nclk_rise),
        .fall_o  (nclk_fall)
    );

    logic unused_sync;
    assign unused_sync = latch_lvl ^ nclk_lvl ^ nclk_fall;

    resp_state_t         state_q, state_d;
    logic [NES_BITS-1:0] shreg_q, shreg_d;
    logic [3:0]          bitcnt_q, bitcnt_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic                dout_q, dout_d;
    logic                fd_q, fd_d;
    logic [NES_BITS-1:0] live;

    always_comb begin
        live             = '0;
        live[BTN_A]      = a;
        live[BTN_B]      = b;
        live[BTN_SELECT] = select;
        live[BTN_START]  = start;
        live[BTN_UP]     = up;
        live[BTN_DOWN]   = down;
        live[BTN_LEFT]   = left;
        live[BTN_RIGHT]  = right;
    end

    always_ff @(posedge clk_900KHz or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            tmo_q    <= '0;
            dout_q   <= REL;
            fd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            tmo_q    <= tmo_d;
            dout_q   <= dout_d;
            fd_q     <= fd_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        tmo_d    = tmo_q;
        dout_d   = dout_q;
        fd_d     = 1'b0;

        // A latch rise restarts from any state and swallows a coincident shift-clock edge.
        if (latch_rise) begin
            state_d  = LOAD;
            shreg_d  = live;
            dout_d   = live[BTN_A] ^ INVERT;
            bitcnt_d = '0;
            tmo_d    = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    shreg_d = '0;
                    dout_d  = REL;
                end
                LOAD: begin
                    shreg_d = live;
                    dout_d  = live[BTN_A] ^ INVERT;
                    if (latch_fall) begin
                        state_d  = SHIFTING;
                        bitcnt_d = '0;
                        tmo_d    = '0;
                    end
                end
                SHIFTING: begin
                    if (nclk_rise) begin
                        shreg_d  = {1'b0, shreg_q[NES_BITS-1:1]};
                        bitcnt_d = (bitcnt_q == 4'(NES_BITS)) ? bitcnt_q : bitcnt_q + 4'd1;
                        tmo_d    = '0;
                        if (bitcnt_q == 4'(NES_BITS - 1)) begin
                            state_d = DONE;
                            dout_d  = REL;
                            fd_d    = 1'b1;
                        end else begin
                            dout_d = shreg_q[1] ^ INVERT;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        state_d = IDLE;
                        shreg_d = '0;
                        dout_d  = REL;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                DONE: begin
                    dout_d = REL;
                end
                default: begin
                    state_d = IDLE;
                    dout_d  = REL;
                end
            endcase
        end
    end

    assign data_out   = dout_q;
    assign busy       = (state_q == LOAD) || (state_q == SHIFTING);
    assign frame_done = fd_q;

endmodule

// File: tb/tb_nes_controller_responder.sv
// Randomized scoreboard bench: two responders (active-low and active-high wire) read by a modelled console.
module tb_nes_controller_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic       latch_in, nesclk_in;
    logic [7:0] btn;
    logic       dout1, busy1, fd1;
    logic       dout0, busy0, fd0;

    always #5 clk = ~clk;

    nes_controller_responder #(.INVERT(1'b1), .TIMEOUT_CYCLES(1024)) u_inv (
        .clk_900KHz (clk),
        .reset      (reset),
        .latch_in   (latch_in),
        .nesclk_in  (nesclk_in),
        .a          (btn[0]),
        .b          (btn[1]),
        .select     (btn[2]),
        .start      (btn[3]),
        .up         (btn[4]),
        .down       (btn[5]),
        .left       (btn[6]),
        .right      (btn[7]),
        .data_out   (dout1),
        .busy       (busy1),
        .frame_done (fd1)
    );

    nes_controller_responder #(.INVERT(1'b0), .TIMEOUT_CYCLES(1024)) u_pos (
        .clk_900KHz (clk),
        .reset      (reset),
        .latch_in   (latch_in),
        .nesclk_in  (nesclk_in),
        .a          (btn[0]),
        .b          (btn[1]),
        .select     (btn[2]),
        .start      (btn[3]),
        .up         (btn[4]),
        .down       (btn[5]),
        .left       (btn[6]),
        .right      (btn[7]),
        .data_out   (dout0),
        .busy       (busy0),
        .frame_done (fd0)
    );

    int    checks = 0;
    int    errors = 0;
    int    fd_cnt1 = 0;
    int    fd_cnt0 = 0;
    int    exp_frames = 0;

    logic  exp1_q[$];
    logic  exp0_q[$];
    string name_q[$];
    event  smp_ev;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Monitor: compares the wire level whenever the console model samples it.
    initial begin
        forever begin
            @(smp_ev);
            if (name_q.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                string nm;
                logic  e1, e0;
                nm = name_q.pop_front();
                e1 = exp1_q.pop_front();
                e0 = exp0_q.pop_front();
                chk({nm, "_inv"}, int'(dout1), int'(e1));
                chk({nm, "_pos"}, int'(dout0), int'(e0));
            end
        end
    end

    always @(negedge clk) begin
        if (fd1 === 1'b1) fd_cnt1++;
        if (fd0 === 1'b1) fd_cnt0++;
    end

    task automatic expect_sample(input string nm, input logic wire_inv, input logic wire_pos);
        name_q.push_back(nm);
        exp1_q.push_back(wire_inv);
        exp0_q.push_back(wire_pos);
        ->smp_ev;
        #0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Console model: 12-cycle latch, then nclks shift pulses of 6 cycles low / 6 high,
    // sampling each bit just before the rising edge that moves past it.
    task automatic frame(input logic [7:0] pat, input int nclks, input logic scramble);
        btn      = pat;
        latch_in = 1'b1;
        cycles(12);
        latch_in = 1'b0;
        for (int k = 0; k < nclks; k++) begin
            cycles(6);
            if (k == 0 && scramble) btn = 8'($urandom);
            if (k == 0) chk("busy_shift", int'(busy1), 1);
            expect_sample($sformatf("bit%0d", k), pat[k] ^ 1'b1, pat[k]);
            nesclk_in = 1'b1;
            cycles(6);
            nesclk_in = 1'b0;
        end
        if (nclks == 8) begin
            exp_frames++;
            cycles(2);
            expect_sample("after", 1'b1, 1'b0);
            chk("busy_done", int'(busy1), 0);
            chk("fd_count_inv", fd_cnt1, exp_frames);
            chk("fd_count_pos", fd_cnt0, exp_frames);
        end
    endtask

    initial begin
        logic [7:0] rp;
        reset     = 1'b1;
        latch_in  = 1'b0;
        nesclk_in = 1'b0;
        btn       = 8'h00;
        cycles(3);
        chk("rst_dout_inv", int'(dout1), 1);
        chk("rst_dout_pos", int'(dout0), 0);
        chk("rst_busy", int'(busy1 | busy0), 0);
        chk("rst_fd", int'(fd1 | fd0), 0);
        reset = 1'b0;
        cycles(2);

        // Shift clocks while idle must not disturb the line.
        btn = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            nesclk_in = 1'b1;
            cycles(6);
            nesclk_in = 1'b0;
            cycles(6);
        end
        expect_sample("idle_clk", 1'b1, 1'b0);
        chk("idle_busy", int'(busy1), 0);
        chk("idle_fd", fd_cnt1, 0);

        frame(8'h89, 8, 1'b1);        // a, start, right
        frame(8'h89, 3, 1'b0);        // aborted by the next latch
        frame(8'h02, 8, 1'b1);        // b only

        // Abandoned frame: two clocks then silence past the timeout.
        frame(8'h55, 2, 1'b0);
        cycles(1100);
        chk("tmo_busy", int'(busy1), 0);
        expect_sample("tmo_level", 1'b1, 1'b0);
        chk("tmo_fd", fd_cnt1, exp_frames);
        frame(8'hC3, 8, 1'b1);

        // Reset in the middle of shifting.
        frame(8'hA5, 4, 1'b0);
        cycles(2);
        reset = 1'b1;
        #1;
        chk("midrst_dout_inv", int'(dout1), 1);
        chk("midrst_dout_pos", int'(dout0), 0);
        chk("midrst_busy", int'(busy1), 0);
        chk("midrst_fd", int'(fd1), 0);
        cycles(2);
        reset = 1'b0;
        cycles(2);
        frame(8'h02, 8, 1'b0);

        for (int n = 0; n < 10; n++) begin
            rp = 8'($urandom);
            frame(rp, 8, 1'b1);
            cycles($urandom_range(0, 5));
        end

        cycles(2);
        chk("sb_empty", name_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nes_controller_responder.md
# nes_controller_responder

Controller-side end of the NES serial pad link: emulates the 4021-style shift register inside a gamepad so that FPGA-generated button states can be read by a console or by our own NES reader. It samples the console's latch and shift-clock lines on the local 900 kHz clock, captures the eight button inputs on latch, and drives them out one bit per shift-clock pulse in A, B, Select, Start, Up, Down, Left, Right order.

## Interface
- INVERT, default 1: 1 means the wire is active-low (pressed = 0, real NES levels); 0 means pressed = 1.
- TIMEOUT_CYCLES, default 1024: clk_900KHz cycles of shift-clock inactivity in SHIFTING before the frame is abandoned.
- clk_900KHz  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- latch_in  input  1  console latch line; asynchronous to clk_900KHz.
- nesclk_in  input  1  console shift-clock line; asynchronous to clk_900KHz.
- a, b, select, start, up, down, left, right  input  1 each  live button states, active-high (1 = pressed).
- data_out  output  1  serial data to the console, registered.
- busy  output  1  high in LOAD and SHIFTING.
- frame_done  output  1  one-cycle pulse when the 8th bit has been shifted past.

## Operation
- latch_in and nesclk_in each pass through a 2-flop synchronizer followed by an edge detector. Only the synchronized signals (latch_s, nclk_s) and their edges are used.
- Released level REL = INVERT. The wire value of bit k is shreg[k] XOR INVERT.
- States:
  - IDLE: shreg = 0; data_out = REL. Shift-clock edges are ignored. Latch rising edge -> LOAD.
  - LOAD: every cycle shreg = {right, left, down, up, start, select, b, a}, and data_out = wire value of live a (transparent parallel load). Shift-clock edges are ignored. Latch falling edge -> SHIFTING, bitcnt = 0, timeout counter cleared. Buttons are captured on the cycle the falling edge is detected.
  - SHIFTING: on an nclk_s rising edge, shreg shifts right with 0 filled in, bitcnt increments, and the timeout counter clears.
    - When bitcnt becomes 8 -> DONE, data_out = REL, frame_done pulses.
    - Otherwise data_out = wire value of the new shreg[0].
    - If the timeout counter reaches TIMEOUT_CYCLES-1 with no edge -> IDLE, data_out = REL, no frame_done.
  - DONE: data_out held at REL; further clock edges have no effect. Latch rising edge -> LOAD.
- A latch rising edge in any state goes to LOAD, aborting a frame in progress. No frame_done is issued for an aborted frame.
- If a latch edge and an nclk edge are detected in the same cycle, the latch edge wins and the clock edge is discarded.
- Button changes after capture do not affect the frame being shifted.
- bitcnt is 4 bits wide and saturates at 8. The timeout counter is $clog2(TIMEOUT_CYCLES) bits wide and does not wrap.

## Timing
- Reset values: data_out = REL, busy = 0, frame_done = 0, state IDLE, shreg = 0, bitcnt = 0, both synchronizers 0.
- Input-edge-to-action latency is 3 cycles: 2 synchronizer stages plus the edge register. data_out updates on the next clock edge, so pin-to-pin latency is at most 4 cycles (about 4.4 µs). This is below a standard 6 µs shift-clock half-period.
- The A bit is valid on data_out no later than 4 cycles after latch_in falls. Each subsequent bit is valid no later than 4 cycles after the corresponding nesclk_in rising edge.
- Input pulses shorter than 2 cycles may be missed. Pulses of 2 cycles or more are always detected.
- Reset asserted mid-frame returns all state to reset values immediately, regardless of the clock.

## Structure
- Package nes_pkg holds:
  - button index constants BTN_A=0 through BTN_RIGHT=7;
  - NES_BITS = 8;
  - state enum resp_state_t {IDLE, LOAD, SHIFTING, DONE}.
- Sub-module nes_edge_sync holds the 2-flop synchronizer plus registered rise/fall detect (outputs: level, rise, fall). It is instantiated once for latch_in and once for nesclk_in.
- Top-level module contains the FSM, shift register, bit counter, timeout counter and output register.

## Test plan
- Reset, INVERT=1: data_out=1, busy=0, frame_done=0; nesclk_in pulses while idle leave data_out at 1.
- Buttons a=1, start=1, right=1, all others 0; 12 µs latch then 8 clock pulses at 6 µs half-period. Sampled wire bits in order: 0,1,1,0,1,1,1,0. frame_done pulses once, then data_out=1.
- Same frame with INVERT=0: wire bits 1,0,0,1,0,0,0,1; idle and after-frame level is 0.
- Latch rising after 3 of 8 clocks, buttons changed to b only: frame restarts; full readout gives 0 at position 1 only (INVERT=1); no frame_done for the aborted frame.
- Latch, then 2 clocks, then silence for more than 1024 cycles: state returns to IDLE, data_out=1, busy=0, no frame_done; the next full frame reads correctly.
- Reset asserted mid-SHIFTING after 4 bits: outputs return to reset values immediately; a following full frame with b=1 reads 1,0,1,1,1,1,1,1.
